tdm_sel_sequencer: RTL and testbench

- Sequential select generator that sits directly upstream of the 4:1 mux / 1:4 demux link and drives its shared 2-bit select.
- Time-division scans the enabled channels in round-robin order and holds each slot for DWELL cycles.
- Emits slot and frame strobes so downstream capture logic knows when the demux output `g` is stable.

---
 rtl/tdm_sel_sequencer.sv | 144 ++++++++++++++
 tb/tb_tdm_sel_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/tdm_sel_sequencer.sv
// Round-robin TDM select generator for the 4:1 mux / 1:4 demux link, with slot/frame strobes.
// Build option: define SEL_GRAY_EN to scan channels in Gray order (0,1,3,2) instead of binary.
module tdm_sel_sequencer #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   ch_mask,
    output logic [SEL_W-1:0] s,
    output logic             slot_valid,
    output logic             slot_end,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned POS_W     = SEL_W + 1;
    localparam logic        ONE_DWELL = (DWELL == 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   dwell_cnt, dwell_cnt_n;
    logic [NCH-1:0]     mask_q, mask_n;
    logic [SEL_W-1:0]   s_n;
    logic               slot_valid_n, slot_end_n, frame_start_n, busy_n;
    logic [POS_W-1:0]   first_hit, next_hit;
    logic               last_dwell;

    // Channel occupying a given scan position.
    function automatic logic [SEL_W-1:0] ch_at(input logic [SEL_W-1:0] p);
`ifdef SEL_GRAY_EN
        return p ^ (p >> 1);
`else
        return p;
`endif
    endfunction

    // Scan position of a channel (inverse of ch_at).
    function automatic logic [SEL_W-1:0] pos_of(input logic [SEL_W-1:0] c);
`ifdef SEL_GRAY_EN
        logic [SEL_W-1:0] r;
        r = c;
        for (int i = 1; i < int'(SEL_W); i++) r = r ^ (c >> i);
        return r;
`else
        return c;
`endif
    endfunction

    // {found, channel} of the first enabled channel at scan position >= start.
    function automatic logic [POS_W-1:0] pick(input logic [NCH-1:0] m, input logic [POS_W-1:0] start);
        logic [POS_W-1:0] r;
        r = '0;
        for (int p = int'(NCH) - 1; p >= 0; p--) begin
            if (POS_W'(p) >= start && m[ch_at(SEL_W'(p))]) r = {1'b1, ch_at(SEL_W'(p))};
        end
        return r;
    endfunction

    assign first_hit  = pick(ch_mask, '0);
    assign next_hit   = pick(mask_q, POS_W'(pos_of(s)) + POS_W'(1));
    assign last_dwell = (dwell_cnt == CNT_W'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dwell_cnt   <= '0;
            mask_q      <= '0;
            s           <= '0;
            slot_valid  <= 1'b0;
            slot_end    <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            dwell_cnt   <= dwell_cnt_n;
            mask_q      <= mask_n;
            s           <= s_n;
            slot_valid  <= slot_valid_n;
            slot_end    <= slot_end_n;
            frame_start <= frame_start_n;
            busy        <= busy_n;
        end
    end

    // Next-state and registered-output logic; strobes default low.
    always_comb begin
        state_n       = state;
        dwell_cnt_n   = dwell_cnt;
        mask_n        = mask_q;
        s_n           = s;
        slot_valid_n  = slot_valid;
        busy_n        = busy;
        slot_end_n    = 1'b0;
        frame_start_n = 1'b0;

        case (state)
            IDLE: begin
                if (en && ch_mask != '0) begin
                    state_n       = SCAN;
                    mask_n        = ch_mask;
                    s_n           = first_hit[SEL_W-1:0];
                    dwell_cnt_n   = '0;
                    slot_valid_n  = 1'b1;
                    busy_n        = 1'b1;
                    frame_start_n = 1'b1;
                    slot_end_n    = ONE_DWELL;
                end
            end
            SCAN: begin
                if (last_dwell) begin
                    dwell_cnt_n = '0;
                    if (next_hit[SEL_W]) begin
                        s_n        = next_hit[SEL_W-1:0];
                        slot_end_n = ONE_DWELL;
                    end else if (en && ch_mask != '0) begin
                        // Frame boundary: resample the mask and restart the scan.
                        mask_n        = ch_mask;
                        s_n           = first_hit[SEL_W-1:0];
                        frame_start_n = 1'b1;
                        slot_end_n    = ONE_DWELL;
                    end else begin
                        state_n      = IDLE;
                        s_n          = '0;
                        slot_valid_n = 1'b0;
                        busy_n       = 1'b0;
                    end
                end else begin
                    dwell_cnt_n = dwell_cnt + CNT_W'(1);
                    slot_end_n  = ((dwell_cnt + CNT_W'(1)) == CNT_W'(DWELL - 1));
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tdm_sel_sequencer.sv
// Directed bench for tdm_sel_sequencer (DWELL=4); expected select order follows SEL_GRAY_EN.
module tb_tdm_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] ch_mask;
    logic [1:0] s;
    logic       slot_valid, slot_end, frame_start, busy;

    int n_checks = 0;
    int n_errors = 0;

    tdm_sel_sequencer #(.NCH(4), .SEL_W(2), .DWELL(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ch_mask    (ch_mask),
        .s          (s),
        .slot_valid (slot_valid),
        .slot_end   (slot_end),
        .frame_start(frame_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel at scan position p.
    function automatic int ord(input int p);
`ifdef SEL_GRAY_EN
        return p ^ (p >> 1);
`else
        return p;
`endif
    endfunction

    // Advance one clock, then compare every output.
    task automatic step(input string tag, input int k, input int sv, input bit se, input bit fs, input bit act);
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d].s", tag, k), int'(s), sv);
        check($sformatf("%s[%0d].slot_valid", tag, k), int'(slot_valid), int'(act));
        check($sformatf("%s[%0d].busy", tag, k), int'(busy), int'(act));
        check($sformatf("%s[%0d].slot_end", tag, k), int'(slot_end), int'(se));
        check($sformatf("%s[%0d].frame_start", tag, k), int'(frame_start), int'(fs));
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        ch_mask = 4'b0000;
        step("por", 0, 0, 0, 0, 0);
        step("por", 1, 0, 0, 0, 0);
        rst = 1'b0;

        // Full scan, then a second frame start at cycle 17.
        en = 1'b1;
        ch_mask = 4'b1111;
        for (int k = 1; k <= 17; k++)
            step("full", k, ord(((k - 1) / 4) % 4), (k % 4) == 0, (k == 1) || (k == 17), 1'b1);

        // Reset mid-scan for two cycles.
        rst = 1'b1;
        step("rst_scan", 0, 0, 0, 0, 0);
        step("rst_scan", 1, 0, 0, 0, 0);
        en = 1'b0;
        rst = 1'b0;
        step("idle", 0, 0, 0, 0, 0);

        // Sparse mask: channels 1 and 3 only.
        en = 1'b1;
        ch_mask = 4'b1010;
        for (int k = 1; k <= 17; k++) begin
            if (k <= 16)
                step("sparse", k, (((k - 1) / 4) % 2) != 0 ? 3 : 1, (k % 4) == 0, (k == 1) || (k == 9), 1'b1);
            else
                step("sparse", k, 0, 0, 0, 0);
            if (k == 12) en = 1'b0;
        end

        // Mask change mid-frame takes effect at the frame boundary; single channel repeats.
        en = 1'b1;
        ch_mask = 4'b1111;
        for (int k = 1; k <= 25; k++) begin
            if (k <= 16)
                step("mchg", k, ord((k - 1) / 4), (k % 4) == 0, k == 1, 1'b1);
            else if (k <= 24)
                step("mchg", k, 0, (k % 4) == 0, (k == 17) || (k == 21), 1'b1);
            else
                step("mchg", k, 0, 0, 0, 0);
            if (k == 5) ch_mask = 4'b0001;
            if (k == 22) en = 1'b0;
        end

        // en dropped during slot 2: remaining slots complete, then IDLE.
        en = 1'b1;
        ch_mask = 4'b1111;
        for (int k = 1; k <= 18; k++) begin
            if (k <= 16)
                step("endrop", k, ord((k - 1) / 4), (k % 4) == 0, k == 1, 1'b1);
            else
                step("endrop", k, 0, 0, 0, 0);
            if (k == 10) en = 1'b0;
        end

        // Empty mask keeps the sequencer idle until a channel is enabled.
        en = 1'b1;
        ch_mask = 4'b0000;
        for (int k = 1; k <= 5; k++) step("empty", k, 0, 0, 0, 0);
        ch_mask = 4'b0100;
        step("empty_go", 1, 2, 0, 1, 1);
        step("empty_go", 2, 2, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
